alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Instruction-side counterpart to the combinational ALU: accepts one 16-bit instruction per handshake.
- Decodes it, reads operands from an internal 16x16 register file and drives A/B/Opcode into the ALU.
- Captures the ALU result and flags, writes back Rdest and updates the processor status register (PSR).
- Sits between instruction fetch and the ALU in the datapath.

Parameters:
- REGS, 16, number of general registers (address width fixed at 4).
- WIDTH, 16, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr  in  16  instruction word.
- instr_ready  out  1  block can accept an instruction.
- alu_a  out  16  ALU operand A (Rdest value).
- alu_b  out  16  ALU operand B (Rsrc value or extended immediate).
- alu_opcode  out  8  ALU opcode.
- alu_c  in  16  ALU result.
- alu_carry  in  1  ALU flag.
- alu_flag  in  1  ALU flag.
- alu_low  in  1  ALU flag.
- alu_negative  in  1  ALU flag.
- alu_zero  in  1  ALU flag.
- psr  out  5  {C,L,F,N,Z} status.
- done  out  1  one-cycle pulse in the cycle after writeback.
- dbg_addr  in  4  register-file debug read address.
- dbg_data  out  16  combinational read of reg[dbg_addr].

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; all registers and psr are cleared to 0.
  - alu_a, alu_b, alu_opcode and done are 0; instr_ready is 1.
  - Reset mid-operation aborts the instruction: no register write and no psr update.
- Fields:
  - op = instr[15:12], rd = instr[11:8], ext = instr[7:4], rs = instr[3:0], imm = instr[7:0].
- Decode:
  - op==0000 (register form): alu_opcode = {0000, ext}, alu_b = reg[rs].
  - op==1000 (shift-immediate): alu_opcode = {1000, ext}, alu_b = zero-extended rs (amount 0..15).
  - All other op (immediate form): alu_opcode = {op, 0000}, alu_b = sign-extended imm.
  - In every case alu_a = reg[rd].
- Classes:
  - Compare: {op,ext}==0000_1011 or op==1011. No writeback; updates L, N, Z.
  - Arithmetic: ext or op in {0101, 0110, 0111, 1001}. Writeback; updates C, F, Z.
  - Logic and shift: writeback; updates Z only.
  - NOP: instr==0x0000. No writeback, no psr change.
- FSM, states IDLE -> ISSUE -> WB -> IDLE:
  - IDLE: instr_ready=1. On instr_valid && instr_ready, latch instr and go to ISSUE.
  - ISSUE: ALU inputs registered and stable for the whole cycle; go to WB.
  - WB: ALU outputs sampled; reg[rd] <= alu_c if the class writes; psr bits updated per class mask (other bits hold); go to IDLE.
  - done=1 in the IDLE cycle following WB.
- Latency and throughput: accept at edge 0, write visible after edge 2, 3-cycle throughput.
- instr_ready=0 in ISSUE and WB; instr_valid is ignored there, with no queuing.
- The ALU is combinational; flags reported as x by it are never sampled, because masked bits are not written.
- alu_a, alu_b and alu_opcode hold their last values in IDLE.
- Writeback to rd==rs is legal: the operand was read before the write.
- dbg_data reflects a write from the cycle after the WB edge.

Test Plan:
- Reset, then ADDI r1,#5 (0x5105) -> reg1=0x0005, psr.Z=0, instr_ready low for 2 cycles, done pulse at cycle 3.
- ADDI r1,#0xFF (0x51FF) after r1=5 -> alu_b=0xFFFF, reg1=0x0004; C=1 if the ALU reports carry for this opcode, else C=0.
- ADDI r5,#0x40 (0x5540); LSHI r5,#8 (0x8508) -> reg5=0x4000; ADD r5,r5 (0x0555) -> reg5=0x8000, psr.F=1, Z=0.
- CMP r1,r5 (0x01B5) with r1=4, r5=0x8000 -> L=1, N=0, Z=0, reg1 unchanged, C/F bits unchanged.
- Hold instr_valid high with a second instruction during ISSUE/WB -> not accepted until IDLE; exactly one write per handshake.
- Drop reset during ISSUE of ADDI r2,#9 -> reg2=0, psr=0, instr_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one instruction per handshake,
// reads operands from a 16x16 register file, then writes back the result and PSR.
module alu_issue_ctrl #(
    parameter int unsigned REGS  = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [7:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_carry,
    input  logic             alu_flag,
    input  logic             alu_low,
    input  logic             alu_negative,
    input  logic             alu_zero,
    output logic [4:0]       psr,
    output logic             done,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    localparam int unsigned AW    = 4;
    localparam int unsigned IW    = 16;
    localparam int unsigned OPW   = 8;
    localparam int unsigned PSRW  = 5;
    localparam int unsigned IMMW  = 8;

    // PSR bit order is {C,L,F,N,Z}
    localparam logic [PSRW-1:0] MASK_CMP   = 5'b01011;
    localparam logic [PSRW-1:0] MASK_ARITH = 5'b10101;
    localparam logic [PSRW-1:0] MASK_LOGIC = 5'b00001;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       instr_q, instr_d;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [OPW-1:0]      opc_q, opc_d;
    logic [PSRW-1:0]     psr_q, psr_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    rf_q [REGS];

    logic [AW-1:0]       in_op, in_rd, in_ext, in_rs;
    logic [AW-1:0]       wb_op, wb_rd, wb_ext;
    logic                wb_nop, wb_cmp, wb_arith, wr_en;
    logic [PSRW-1:0]     wb_mask, alu_flags;

    function automatic logic arith_code(input logic [AW-1:0] code);
        return code inside {4'h5, 4'h6, 4'h7, 4'h9};
    endfunction

    assign in_op  = instr[15:12];
    assign in_rd  = instr[11:8];
    assign in_ext = instr[7:4];
    assign in_rs  = instr[3:0];
    assign wb_op  = instr_q[15:12];
    assign wb_rd  = instr_q[11:8];
    assign wb_ext = instr_q[7:4];

    assign alu_flags = {alu_carry, alu_low, alu_flag, alu_negative, alu_zero};

    // Instruction class of the latched instruction, used only in WB
    always_comb begin
        wb_nop   = (instr_q == '0);
        wb_cmp   = ((wb_op == 4'h0) && (wb_ext == 4'hB)) || (wb_op == 4'hB);
        wb_arith = (wb_op == 4'h0) ? arith_code(wb_ext) : arith_code(wb_op);
        if (wb_nop) begin
            wb_mask = '0;
        end else if (wb_cmp) begin
            wb_mask = MASK_CMP;
        end else if (wb_arith) begin
            wb_mask = MASK_ARITH;
        end else begin
            wb_mask = MASK_LOGIC;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        opc_d   = opc_q;
        psr_d   = psr_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d = S_ISSUE;
                    instr_d = instr;
                    alu_a_d = rf_q[in_rd];
                    if (in_op == 4'h0) begin
                        opc_d   = {4'h0, in_ext};
                        alu_b_d = rf_q[in_rs];
                    end else if (in_op == 4'h8) begin
                        opc_d   = {4'h8, in_ext};
                        alu_b_d = WIDTH'(in_rs);
                    end else begin
                        opc_d   = {in_op, 4'h0};
                        alu_b_d = {{(WIDTH-IMMW){instr[IMMW-1]}}, instr[IMMW-1:0]};
                    end
                end
            end
            S_ISSUE: state_d = S_WB;
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                wr_en   = !wb_nop && !wb_cmp;
                psr_d   = (psr_q & ~wb_mask) | (alu_flags & wb_mask);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            opc_q   <= '0;
            psr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            opc_q   <= opc_d;
            psr_q   <= psr_d;
            done_q  <= done_d;
        end
    end

    // Register file; reset clears every entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(REGS); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            rf_q[wb_rd] <= alu_c;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = opc_q;
    assign psr         = psr_q;
    assign done        = done_q;
    assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a stand-in ALU, an instruction-level
// reference model feeding an expectation queue, and a done-driven monitor.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [7:0]  alu_opcode;
    logic        alu_carry, alu_flag, alu_low, alu_negative, alu_zero;
    logic [4:0]  psr;
    logic        done;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  rd;
        logic        wr;
        logic [4:0]  psr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        r;
    logic [15:0] ref_rf    [16];
    logic [15:0] shadow_rf [16];
    logic [4:0]  ref_psr;
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bsy = 0;
    bit          in_reset = 1'b1;
    logic [4:0]  junk = '0;
    logic [15:0] sa_c;
    logic [4:0]  sa_fl, sa_keep;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_c(alu_c), .alu_carry(alu_carry), .alu_flag(alu_flag), .alu_low(alu_low),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .psr(psr), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #50 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        junk <= 5'($urandom);
    end

    // Behavioural ALU: add/sub/logic/shift/compare with {C,L,F,N,Z} flags
    function automatic void alu_ref(input logic [7:0] opc, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] c,
                                    output logic [4:0] fl);
        logic [16:0] s;
        logic [3:0]  sel;
        logic        cy, ov, z;
        cy  = 1'b0;
        ov  = 1'b0;
        sel = (opc[7:4] == 4'h0) ? opc[3:0] : opc[7:4];
        if (opc[7:4] == 4'h8) begin
            c = a << b[3:0];
        end else begin
            case (sel)
                4'h5, 4'h6, 4'h7: begin
                    s  = {1'b0, a} + {1'b0, b};
                    c  = s[15:0];
                    cy = s[16];
                    ov = (a[15] == b[15]) && (c[15] != a[15]);
                end
                4'h9: begin
                    s  = {1'b0, a} - {1'b0, b};
                    c  = s[15:0];
                    cy = s[16];
                    ov = (a[15] != b[15]) && (c[15] != a[15]);
                end
                4'h1:    c = a & b;
                4'h2:    c = a | b;
                4'h3:    c = a ^ b;
                4'hD:    c = b;
                default: c = a ^ ~b;
            endcase
        end
        z  = (sel == 4'hB) ? (a == b) : (c == 16'h0);
        fl = {cy, a < b, ov, $signed(a) < $signed(b), z};
    endfunction

    // Flags an ALU would define for an opcode; the rest are driven with junk
    function automatic logic [4:0] opc_mask(input logic [7:0] opc);
        if (opc == 8'h0B || opc == 8'hB0) return 5'b01011;
        if (opc inside {8'h05, 8'h06, 8'h07, 8'h09, 8'h50, 8'h60, 8'h70, 8'h90}) return 5'b10101;
        return 5'b00001;
    endfunction

    function automatic logic [4:0] class_mask(input logic [15:0] ins);
        logic [3:0] op, ext;
        op  = ins[15:12];
        ext = ins[7:4];
        if (ins == 16'h0) return 5'b00000;
        if ((op == 4'h0 && ext == 4'hB) || op == 4'hB) return 5'b01011;
        if (op == 4'h0 ? (ext inside {4'h5, 4'h6, 4'h7, 4'h9})
                       : (op inside {4'h5, 4'h6, 4'h7, 4'h9})) return 5'b10101;
        return 5'b00001;
    endfunction

    always_comb begin
        alu_ref(alu_opcode, alu_a, alu_b, sa_c, sa_fl);
        sa_keep = opc_mask(alu_opcode);
    end
    assign alu_c = sa_c;
    assign {alu_carry, alu_low, alu_flag, alu_negative, alu_zero} =
        (sa_fl & sa_keep) | (junk & ~sa_keep);

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sweep(input string tag, input bit zero);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk($sformatf("%s_rf%0d", tag, i), dbg_data, zero ? 16'h0 : shadow_rf[i]);
        end
    endtask

    task automatic model_issue(input logic [15:0] ins);
        exp_t       e;
        logic [3:0] op;
        logic [4:0] fl, m;
        op    = ins[15:12];
        e.ins = ins;
        e.rd  = ins[11:8];
        e.a   = ref_rf[e.rd];
        if (op == 4'h0) begin
            e.opc = {4'h0, ins[7:4]};
            e.b   = ref_rf[ins[3:0]];
        end else if (op == 4'h8) begin
            e.opc = {4'h8, ins[7:4]};
            e.b   = {12'h0, ins[3:0]};
        end else begin
            e.opc = {op, 4'h0};
            e.b   = {{8{ins[7]}}, ins[7:0]};
        end
        alu_ref(e.opc, e.a, e.b, e.res, fl);
        m    = class_mask(ins);
        e.wr = (ins != 16'h0) && (m != 5'b01011);
        if (e.wr) ref_rf[e.rd] = e.res;
        ref_psr = (ref_psr & ~m) | (fl & m);
        e.psr   = ref_psr;
        e.acc   = cyc;
        q.push_back(e);
    endtask

    // Drive one cycle from a negedge; the model decides acceptance from its own busy count
    task automatic cycle(input logic v, input logic [15:0] ins);
        instr_valid = v;
        instr       = ins;
        @(negedge clk);
        if (v && bsy == 0) begin
            model_issue(ins);
            bsy = 2;
        end else if (bsy > 0) begin
            bsy--;
        end
        chk("instr_ready", 16'(instr_ready), 16'(bsy == 0));
    endtask

    task automatic send(input logic [15:0] ins);
        cycle(1'b1, ins);
        cycle(1'b1, 16'($urandom));
        cycle(1'b0, 16'h0);
    endtask

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            ref_rf[i]    = '0;
            shadow_rf[i] = '0;
        end
        ref_psr = '0;
        bsy     = 0;
    endtask

    task automatic post_reset_checks(input string tag);
        chk({tag, "_ready"}, 16'(instr_ready), 16'd1);
        chk({tag, "_done"}, 16'(done), 16'd0);
        chk({tag, "_psr"}, 16'(psr), 16'd0);
        chk({tag, "_alu_a"}, alu_a, 16'd0);
        chk({tag, "_alu_b"}, alu_b, 16'd0);
        chk({tag, "_opcode"}, 16'(alu_opcode), 16'd0);
        sweep(tag, 1'b1);
    endtask

    function automatic logic [15:0] gen();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 5))
            0, 1:    w[15:12] = 4'h0;
            2:       w[15:12] = 4'h8;
            3:       w[15:12] = 4'h5;
            default: ;
        endcase
        if ($urandom_range(0, 15) == 0) w = 16'h0;
        return w;
    endfunction

    // Monitor: every done pulse retires the oldest expectation
    always @(negedge clk) begin
        if (!in_reset) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 16'(done), 16'd0);
                end else begin
                    r = q.pop_front();
                    chk("done_latency", 16'(cyc - r.acc), 16'd2);
                    chk("alu_opcode", 16'(alu_opcode), 16'(r.opc));
                    chk("alu_a", alu_a, r.a);
                    chk("alu_b", alu_b, r.b);
                    chk("psr", 16'(psr), 16'(r.psr));
                    if (r.wr) shadow_rf[r.rd] = r.res;
                    sweep("wb", 1'b0);
                end
            end else if (q.size() > 0 && (cyc - q[0].acc) >= 2) begin
                chk("done_missing", 16'(done), 16'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        post_reset_checks("por");

        send(16'h5105);
        send(16'h51FF);
        send(16'h5540);
        send(16'h8508);
        send(16'h0555);
        send(16'h01B5);
        cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        dbg_addr = 4'd1;
        #1 chk("plan_r1", dbg_data, 16'h0004);
        dbg_addr = 4'd5;
        #1 chk("plan_r5", dbg_data, 16'h8000);
        chk("plan_psr", 16'(psr), 16'b01100);

        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 3) != 0), gen());
        end
        repeat (4) cycle(1'b0, 16'h0);
        chk("queue_drained", 16'(q.size()), 16'd0);

        // Reset while an ADDI r2,#9 sits in ISSUE
        cycle(1'b1, 16'h5209);
        instr_valid = 1'b0;
        in_reset    = 1'b1;
        reset       = 1'b0;
        @(negedge clk);
        clear_model();
        reset = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        post_reset_checks("midop");
        repeat (3) cycle(1'b0, 16'h0);
        chk("midop_psr_hold", 16'(psr), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
